imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader that acts as the write side of the processor's instruction memory port: the core only reads the memory, and this block fills it. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them to consecutive addresses from 0. It checks the stream against a length header and an XOR checksum, and holds the core in reset until a load completes cleanly.

## Interface
Parameters:
- size, 32, instruction word width in bits
- MemSize, 512, instruction memory depth in words
- AddrWidth, 9, instruction memory address width (log2 MemSize)

Ports:
- clk  input  1  clock; the only clock domain
- reset  input  1  synchronous, active-high; takes effect at the next rising clk edge
- in_data  input  8  stream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts a byte this cycle
- start  input  1  one-cycle pulse that restarts a load from DONE or ERROR
- wea  output  1  instruction memory write enable, one-cycle pulse
- addra  output  AddrWidth  instruction memory write address
- dina  output  size  instruction memory write data
- cpu_hold  output  1  keeps the processor in reset while high
- done  output  1  load completed and checksum matched
- error  output  1  load aborted
- words_loaded  output  16  number of words written in the current or last load

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes (MSB first per word), then one checksum byte.
- Checksum: XOR of every byte before it, including both length bytes.
- A byte is accepted on a rising edge where in_valid and in_ready are both 1.
- States:
  - IDLE: entered on reset; moves to LEN_HI on the next cycle.
  - LEN_HI: accept the high length byte, then go to LEN_LO.
  - LEN_LO: accept the low length byte. If N > MemSize, go to ERROR. If N = 0, go to CSUM. Otherwise go to DATA.
  - DATA: shift bytes into the word assembler. On the 4th byte of a word, issue the write and increment the word index. After word N−1 is written, go to CSUM.
  - CSUM: accept the checksum byte. If it equals the running XOR, go to DONE; otherwise go to ERROR.
  - DONE and ERROR: hold. A start pulse clears the running XOR, the word index and words_loaded, then moves to LEN_HI.
- in_ready = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in IDLE, DONE and ERROR.
- cpu_hold = 0 only in DONE.
- done = 1 only in DONE; error = 1 only in ERROR.
- Memory contents written before an error are left as they are; cpu_hold stays high.
- A start pulse outside DONE or ERROR is ignored.

## Timing
- Reset values: state IDLE, in_ready 0, wea 0, addra 0, dina 0, cpu_hold 1, done 0, error 0, words_loaded 0, running XOR 0.
- in_ready is a function of the registered state only; it has no combinational path from in_valid.
- Write latency:
  - wea, addra and dina are registered. wea is high for exactly the one cycle after the handshake of a word's 4th byte.
  - addra equals the word index before the increment.
  - words_loaded increments in the same cycle that wea is high.
- Throughput: one byte per cycle. A write for word k may overlap acceptance of the first byte of word k+1.
- State transition timing: DATA → CSUM is taken on the edge that accepts the final data byte. The last write (wea=1) happens during the first CSUM cycle.
- DONE is entered on the edge that accepts a correct checksum byte; cpu_hold falls to 0 in that same cycle.
- If reset and a byte handshake occur in the same cycle, reset wins and the byte is dropped.
- Reset in the middle of a load aborts it and returns all outputs to their reset values. The partial memory image is not cleared.

## Structure
- Shared package contents:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR)
  - constant LEN_BYTES = 2
  - constant BYTES_PER_WORD = 4
- Sub-module word_assembler:
  - 32-bit shift register plus 2-bit byte counter
  - inputs: byte, shift, clear
  - outputs: word, word_complete pulse
- The top level holds the FSM, running XOR, word index and the registered memory-write outputs.

## Test plan
- Stream 00 01 8C 20 00 04 A9 → single wea pulse with addra=0, dina=0x8C200004; then done=1, cpu_hold=0, words_loaded=1.
- Same stream but checksum 00 → one write occurs; error=1, cpu_hold=1, done=0.
- Length 0x0201 (513) → error=1 on the cycle after LEN_LO is accepted; wea never asserts.
- Three words streamed back-to-back with in_valid held high, checksum correct → wea high on three cycles spaced 4 apart, addra 0, 1, 2; done=1.
- in_valid toggled randomly during a two-word load → same memory image and final state as the back-to-back case.
- Reset asserted after 5 data bytes, then a good 1-word stream, then start followed by a 0-length stream (00 00 00) → first: outputs at reset values then done=1; second: done=1 with no wea and words_loaded=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a byte stream MSB-first into words; flags the byte that completes a word.
// Latency: word/word_complete are combinational on the completing byte.
// Backpressure: none; shift is only pulsed on an accepted byte.
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      in_byte,
    input  logic            shift,
    input  logic            clear,
    output logic [size-1:0] word,
    output logic            word_complete
);

    // Only the first three bytes of a word need storing; the fourth is the live input.
    logic [size-9:0] shreg;
    logic [1:0]      cnt;

    assign word          = {shreg, in_byte};
    assign word_complete = shift && (cnt == 2'(BYTES_PER_WORD - 1));

    // Shift accepted bytes in and count position within the current word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= word[size-9:0];
            cnt   <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed, XOR-checked byte stream -> instruction memory writes.
// Latency: write strobe one cycle after a word's 4th byte; one byte per cycle.
// Backpressure: in_ready depends only on registered state (high while loading).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int size      = 32,
    parameter int MemSize   = 512,
    parameter int AddrWidth = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 start,
    output logic                 wea,
    output logic [AddrWidth-1:0] addra,
    output logic [size-1:0]      dina,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 error,
    output logic [15:0]          words_loaded
);

    state_t          state, next_state;
    logic [7:0]      len_hi;
    logic [15:0]     len;
    logic [15:0]     len_next;
    logic [15:0]     word_idx;
    logic [7:0]      xor_acc;
    logic            accept;
    logic            restart;
    logic            shift;
    logic [size-1:0] word;
    logic            word_complete;

    assign accept   = in_valid && in_ready;
    assign len_next = {len_hi, in_data};
    assign restart  = start && ((state == DONE) || (state == ERROR));
    assign shift    = accept && (state == DATA);

    word_assembler #(.size(size)) u_asm (
        .clk           (clk),
        .reset         (reset),
        .in_byte       (in_data),
        .shift         (shift),
        .clear         (restart),
        .word          (word),
        .word_complete (word_complete)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and status decode from the registered state.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        unique case (state)
            IDLE: next_state = LEN_HI;
            LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) next_state = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_next > 16'(MemSize)) next_state = ERROR;
                    else if (len_next == 16'd0)  next_state = CSUM;
                    else                         next_state = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (word_complete && (word_idx == len - 16'd1)) next_state = CSUM;
            end
            CSUM: begin
                in_ready = 1'b1;
                if (in_valid) next_state = (in_data == xor_acc) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (start) next_state = LEN_HI;
            end
            default: next_state = IDLE;
        endcase
    end

    assign cpu_hold     = (state != DONE);
    assign done         = (state == DONE);
    assign error        = (state == ERROR);
    assign words_loaded = word_idx;

    // Length capture, running checksum, word index and registered memory write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi   <= '0;
            len      <= '0;
            xor_acc  <= '0;
            word_idx <= '0;
            wea      <= 1'b0;
            addra    <= '0;
            dina     <= '0;
        end else begin
            wea <= word_complete;
            if (word_complete) begin
                addra    <= word_idx[AddrWidth-1:0];
                dina     <= word;
                word_idx <= word_idx + 16'd1;
            end
            // The checksum byte itself is compared, not folded in.
            if (accept && (state != CSUM)) xor_acc <= xor_acc ^ in_data;
            if (accept && (state == LEN_HI)) len_hi <= in_data;
            if (accept && (state == LEN_LO)) len <= len_next;
            if (restart) begin
                xor_acc  <= '0;
                word_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader against a stream-level model.
// Latency: n/a.
// Backpressure: driver honours in_ready, optionally inserting random idle cycles.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        wea;
    logic [8:0]  addra;
    logic [31:0] dina;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .start        (start),
        .wea          (wea),
        .addra        (addra),
        .dina         (dina),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream under test and the model's expectations for it.
    logic [7:0]  stream[$];
    logic [31:0] exp_words[$];
    bit          exp_good;
    bit          exp_oversize;

    // Observed memory writes.
    logic [8:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (wea) begin
            wr_addr.push_back(addra);
            wr_data.push_back(dina);
            wr_cyc.push_back(cyc);
            check_val("wl_at_wea", 32'(words_loaded), 32'(addra) + 32'd1);
        end
    end

    function automatic logic [7:0] stream_xor();
        logic [7:0] x = 8'h00;
        foreach (stream[i]) x = x ^ stream[i];
        return x;
    endfunction

    task automatic make_stream(input int n, input bit bad);
        logic [31:0] w;
        logic [7:0]  cs;
        stream.delete();
        exp_words.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_words.push_back(w);
            for (int b = 3; b >= 0; b--) stream.push_back(w[b*8 +: 8]);
        end
        cs = stream_xor();
        if (bad) cs = cs ^ 8'($urandom_range(1, 255));
        stream.push_back(cs);
        exp_good     = !bad;
        exp_oversize = 1'b0;
    endtask

    // Called and returns at a negedge; the byte is taken on the posedge in between.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check_val("ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_val({tag, "_wea"}, 32'(wea), 32'd0);
        check_val({tag, "_addra"}, 32'(addra), 32'd0);
        check_val({tag, "_dina"}, dina, 32'd0);
        check_val({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_error"}, 32'(error), 32'd0);
        check_val({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic run_and_check(input string name, input bit gaps);
        bit ok;
        int nw;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        foreach (stream[i]) send_byte(stream[i], gaps);
        ok = exp_good && !exp_oversize;
        nw = exp_oversize ? 0 : exp_words.size();
        // Final state is entered on the edge that takes the last byte.
        check_val({name, "_done"}, 32'(done), 32'(ok));
        check_val({name, "_error"}, 32'(error), 32'(!ok));
        check_val({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!ok));
        repeat (2) @(negedge clk);
        check_val({name, "_in_ready"}, 32'(in_ready), 32'd0);
        check_val({name, "_words"}, 32'(words_loaded), 32'(nw));
        check_val({name, "_nwrites"}, 32'(wr_addr.size()), 32'(nw));
        for (int i = 0; i < wr_addr.size() && i < nw; i++) begin
            check_val({name, "_addr"}, 32'(wr_addr[i]), 32'(i));
            check_val({name, "_data"}, wr_data[i], exp_words[i]);
            if (!gaps && i > 0) check_val({name, "_spacing"}, 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd4);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // Single known word, correct checksum.
        stream       = '{8'h00, 8'h01, 8'h8C, 8'h20, 8'h00, 8'h04, 8'hA9};
        exp_words    = '{32'h8C200004};
        exp_good     = 1'b1;
        exp_oversize = 1'b0;
        run_and_check("one_word", 1'b0);

        // Same stream, wrong checksum: write still happens, load fails.
        pulse_start();
        stream    = '{8'h00, 8'h01, 8'h8C, 8'h20, 8'h00, 8'h04, 8'h00};
        exp_good  = 1'b0;
        run_and_check("bad_csum", 1'b0);

        // Length one past memory depth.
        pulse_start();
        stream       = '{8'h02, 8'h01};
        exp_words.delete();
        exp_oversize = 1'b1;
        run_and_check("oversize", 1'b0);

        // Three words back to back.
        pulse_start();
        make_stream(3, 1'b0);
        run_and_check("three_b2b", 1'b0);

        // Two words with ragged valid.
        pulse_start();
        make_stream(2, 1'b0);
        run_and_check("two_gaps", 1'b1);

        // Exactly memory depth.
        pulse_start();
        make_stream(512, 1'b0);
        run_and_check("full_mem", 1'b0);

        // Random loads.
        for (int k = 0; k < 12; k++) begin
            pulse_start();
            make_stream($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
            run_and_check("random", 1'(($urandom_range(0, 1))));
        end

        // Reset mid-load, colliding with a byte handshake.
        pulse_start();
        make_stream(3, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(stream[i], 1'b0);
        in_valid = 1'b1;
        in_data  = stream[7];
        reset    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_reset_vals("mid_reset");
        reset = 1'b0;
        make_stream(1, 1'b0);
        run_and_check("after_reset", 1'b0);

        // Zero-length load.
        pulse_start();
        stream       = '{8'h00, 8'h00, 8'h00};
        exp_words.delete();
        exp_good     = 1'b1;
        exp_oversize = 1'b0;
        run_and_check("zero_len", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
